irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the 8 external interrupt lines and the CPU5_5 core.
- Latches rising edges on the interrupt lines and applies a per-line mask and a global enable.
- Raises one request at a time to the CPU, lowest index wins, through an irq/ack handshake.
- Holds an in-service state until the CPU writes end-of-interrupt (EOI).
- Sits on the CPU data bus (Addr/Dout/write/Din) beside the RAM and the output-port registers.

Parameters:
- BASE_ADDR, 16'h0010, word address of the first controller register; the block decodes BASE_ADDR..BASE_ADDR+3.
- N_IRQ, 8, number of interrupt lines, legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- addr  input  16  CPU bus word address.
- wdata  input  16  CPU write data.
- write  input  1  CPU write strobe, qualified by addr.
- rdata  output  16  read data; combinational from addr; 0 when addr is outside the block's range.
- sel  output  1  1 when addr is in BASE_ADDR..BASE_ADDR+3; used by the top-level read mux.
- int_in  input  N_IRQ  asynchronous interrupt lines.
- irq  output  1  interrupt request to the CPU.
- irq_ack  input  1  one-cycle CPU acknowledge.
- vector  output  4  index of the line being requested or serviced.

Behaviour:
- Reset: pending=0, mask=0, gie=0, both synchronizer stages=0, edge history=0, state=IDLE, vector=0, irq=0.
- Input path:
  - int_in passes through a 2-flop synchronizer, then a rising-edge detector (sync & ~prev).
  - A rising edge sets pending[i].
  - Latency: int_in rises before clock edge 0, so pending[i]=1 after edge 2.
  - Levels are not re-detected; a line held high sets pending once.
- Registers (offset from BASE_ADDR):
  - +0 PEND: read {0, pending}. Write-1-to-clear. A new edge and a W1C on the same bit in the same cycle: set wins.
  - +1 MASK: read/write, bits N_IRQ-1:0. 1 = enabled.
  - +2 CTRL: bit0 = gie (global enable). Other bits read 0.
  - +3 STAT/EOI: read {state==SERV, 7'b0, state!=IDLE, 3'b0, vector}. Any write = EOI.
  - Unused upper bits read 0.
- FSM, states IDLE, REQ, SERV:
  - IDLE: if gie and (pending & mask) != 0, latch vector = lowest set index of (pending & mask) and go to REQ.
  - REQ: irq=1 (registered, asserted the cycle after entry).
    - On irq_ack: clear pending[vector], go to SERV.
    - If gie=0 or mask[vector]=0 (and no ack): go to IDLE, irq drops, pending is kept.
    - If irq_ack and the abort condition occur in the same cycle, ack wins.
  - SERV: irq=0. No nesting; new edges only accumulate in pending. EOI write goes to IDLE.
  - A new request can be raised the cycle after return to IDLE.
- Stray events:
  - irq_ack outside REQ: ignored.
  - EOI outside SERV: ignored.
  - A W1C clearing pending[vector] while in REQ: abort to IDLE. An ack in the same cycle still wins.
- vector holds its value in SERV and IDLE until the next latch.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); irq drops without waiting for a clock.

Decomposition:
- Shared package irq_pkg holds:
  - register offsets OFF_PEND=0, OFF_MASK=1, OFF_CTRL=2, OFF_STAT=3;
  - FSM state encoding IDLE/REQ/SERV (2-bit);
  - CTRL_GIE_BIT=0.
- One sub-module, irq_prio_enc: combinational lowest-index priority encoder over N_IRQ bits, outputs {valid, index[3:0]}.

Test Plan:
- Reset with all int_in=0 → irq=0, vector=0, read +0/+1/+2/+3 = 16'h0000.
- MASK=8'h0F, CTRL=1, pulse int_in[5] → PEND=16'h0020, irq stays 0. Clearing bit 5 via W1C → PEND=0.
- MASK=8'hFF, CTRL=1, int_in[6] and int_in[2] rise together → irq=1, vector=2. After irq_ack: irq=0, STAT=16'h8082, PEND=16'h0040. After EOI: next cycle vector=6 and irq=1.
- In REQ for line 3, write CTRL=0 → irq falls the next cycle, state IDLE, PEND bit3 still 1. Rewrite CTRL=1 → irq re-asserts with vector=3.
- int_in[1] edge arrives in the same cycle as a W1C of bit 1 → PEND bit1=1 afterwards.
- Assert rst while in SERV → irq=0, STAT=0, MASK=0 immediately. Write to an address outside the range (BASE_ADDR+4) → no register change, sel=0, rdata=0.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   - register offsets within the controller's 4-word window
//   - FSM state encoding
//   - CTRL register bit positions
package irq_pkg;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  localparam int CTRL_GIE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder.
//   req   : N_IRQ request bits
//   valid : 1 when any request bit is set
//   index : position of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [3:0]       index
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 4'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the CPU data bus.
//   clk, rst  : clock, asynchronous active-high reset
//   addr      : bus word address; block decodes BASE_ADDR..BASE_ADDR+3
//   wdata     : bus write data, write: write strobe
//   rdata     : combinational read data (0 outside the window), sel: in-window
//   int_in    : asynchronous interrupt lines (rising-edge sensitive)
//   irq       : registered interrupt request, irq_ack: one-cycle acknowledge
//   vector    : index of the line being requested / serviced
// Registers: +0 PEND (W1C), +1 MASK, +2 CTRL (bit0 gie), +3 STAT / EOI.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter int          N_IRQ     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             write,
  output logic [15:0]      rdata,
  output logic             sel,
  input  logic [N_IRQ-1:0] int_in,
  output logic             irq,
  input  logic             irq_ack,
  output logic [3:0]       vector
);

  logic [N_IRQ-1:0] sync1, sync2, prev;
  logic [N_IRQ-1:0] pending, mask;
  logic             gie;
  irq_state_t       state, state_nx;

  logic [15:0]      off;
  logic [1:0]       reg_off;
  logic             wr_pend, wr_mask, wr_ctrl, wr_stat;
  logic [N_IRQ-1:0] rise, clr, ack_clr;
  logic [15:0]      mask_x, ack_onehot;
  logic             req_valid;
  logic [3:0]       req_idx;
  logic             latch_vec, ack_take, irq_nx;

  // Subtracting the base lets one compare cover the window and wraps safely.
  assign off     = addr - BASE_ADDR;
  assign sel     = (off[15:2] == 14'd0);
  assign reg_off = off[1:0];
  assign wr_pend = write && sel && (reg_off == OFF_PEND);
  assign wr_mask = write && sel && (reg_off == OFF_MASK);
  assign wr_ctrl = write && sel && (reg_off == OFF_CTRL);
  assign wr_stat = write && sel && (reg_off == OFF_STAT);

  assign rise = sync2 & ~prev;

  // 16-bit views so a 4-bit vector can index them for any N_IRQ.
  always_comb begin
    mask_x             = '0;
    mask_x[N_IRQ-1:0]  = mask;
  end
  assign ack_onehot = 16'(1) << vector;
  assign ack_clr    = ack_onehot[N_IRQ-1:0];

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req   (pending & mask),
    .valid (req_valid),
    .index (req_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state. In REQ an ack takes priority over every abort cause.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (gie && req_valid) state_nx = REQ;
      REQ: begin
        if (irq_ack)
          state_nx = SERV;
        else if (!gie || !mask_x[vector] || (wr_pend && wdata[vector]))
          state_nx = IDLE;
      end
      SERV: if (wr_stat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs / side effects of the transition.
  always_comb begin
    latch_vec = (state == IDLE) && (state_nx == REQ);
    ack_take  = (state == REQ) && irq_ack;
    irq_nx    = (state_nx == REQ);
  end

  // A new edge beats any clear (W1C or ack) on the same bit.
  assign clr = (wr_pend ? wdata[N_IRQ-1:0] : '0) | (ack_take ? ack_clr : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
      irq     <= 1'b0;
      vector  <= '0;
    end else begin
      sync1   <= int_in;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= (pending & ~clr) | rise;
      if (wr_mask) mask <= wdata[N_IRQ-1:0];
      if (wr_ctrl) gie  <= wdata[CTRL_GIE_BIT];
      irq <= irq_nx;
      if (latch_vec) vector <= req_idx;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (reg_off)
        OFF_PEND: rdata[N_IRQ-1:0]    = pending;
        OFF_MASK: rdata[N_IRQ-1:0]    = mask;
        OFF_CTRL: rdata[CTRL_GIE_BIT] = gie;
        OFF_STAT: begin
          rdata[15]  = (state == SERV);
          rdata[7]   = (state != IDLE);
          rdata[3:0] = vector;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule
